// File: rtl/cla_adder_5bit_if.sv
// Operand/result bundle for the 5-bit carry-lookahead adder.
// The master drives the addends; the slave returns the registered sum and carry.
interface cla_adder_5bit_if;
  logic [4:0] a;
  logic [4:0] b;
  logic [4:0] sum;
  logic       cout;

  modport master (
    output a,
    output b,
    input  sum,
    input  cout
  );

  modport slave (
    input  a,
    input  b,
    output sum,
    output cout
  );
endinterface

// File: rtl/cla_adder_5bit.sv
// 5-bit carry-lookahead adder with a registered result (one-cycle latency).
// Carries are flat two-level generate/propagate products; no ripple path.
module cla_adder_5bit (
  input  logic                 clk,
  input  logic                 rst,
  cla_adder_5bit_if.slave      bus
);

  logic [4:0] w_g;
  logic [4:0] w_p;
  logic [5:0] w_c;
  logic [4:0] w_s;

  logic [4:0] r_sum;
  logic       r_cout;

  always_comb begin
    w_g = bus.a & bus.b;
    w_p = bus.a ^ bus.b;
  end

  // Each carry is expanded directly from g/p so every c[i] is two gate levels deep.
  always_comb begin
    w_c[0] = 1'b0;
    w_c[1] = w_g[0];
    w_c[2] = w_g[1]
           | (w_p[1] & w_g[0]);
    w_c[3] = w_g[2]
           | (w_p[2] & w_g[1])
           | (w_p[2] & w_p[1] & w_g[0]);
    w_c[4] = w_g[3]
           | (w_p[3] & w_g[2])
           | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    w_c[5] = w_g[4]
           | (w_p[4] & w_g[3])
           | (w_p[4] & w_p[3] & w_g[2])
           | (w_p[4] & w_p[3] & w_p[2] & w_g[1])
           | (w_p[4] & w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  end

  always_comb begin
    w_s = w_p ^ w_c[4:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_s;
      r_cout <= w_c[5];
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_cla_adder_5bit.sv
// Scoreboard bench for cla_adder_5bit: a driver queues expected results from
// an arithmetic reference, and an independent monitor compares each cycle.
module tb_cla_adder_5bit;

  logic clk;
  logic rst;

  cla_adder_5bit_if bus ();

  cla_adder_5bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [5:0] exp;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] ref_model(input int unsigned x, input int unsigned y,
                                           input bit r);
    int unsigned total;
    total = x + y;
    return r ? 6'd0 : total[5:0];
  endfunction

  // Drive one cycle of inputs at the falling edge; the next rising edge captures them.
  // With glitch set, inputs hold junk briefly before settling well ahead of the edge.
  task automatic apply(input int unsigned x, input int unsigned y, input bit r,
                       input string tag, input bit glitch = 0);
    exp_t e;
    @(negedge clk);
    if (glitch) begin
      bus.a = 5'($urandom);
      bus.b = 5'($urandom);
      #1;
    end
    bus.a = 5'(x);
    bus.b = 5'(y);
    rst   = r;
    e.exp = ref_model(x, y, r);
    e.tag = tag;
    q.push_back(e);
  endtask

  // Monitor: one result per rising edge, sampled 1 ns after the edge.
  initial begin
    exp_t       e;
    logic [5:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e   = q.pop_front();
        got = {bus.cout, bus.sum};
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s: got cout=%b sum=%b, expected cout=%b sum=%b",
                   e.tag, got[5], got[4:0], e.exp[5], e.exp[4:0]);
        end
      end
    end
  end

  // Hold check: outputs must not move between edges even as inputs change.
  initial begin
    logic [5:0] snap;
    forever begin
      @(posedge clk);
      #2;
      snap = {bus.cout, bus.sum};
      @(negedge clk);
      #2;
      if (!done && q.size() != 0) begin
        checks++;
        if ({bus.cout, bus.sum} !== snap) begin
          errors++;
          $display("FAIL hold_between_edges: got %b, expected %b", {bus.cout, bus.sum}, snap);
        end
      end
    end
  end

  initial begin
    int unsigned ra;
    int unsigned rb;
    bit          rr;
    int          budget;

    rst   = 1'b1;
    bus.a = 5'd0;
    bus.b = 5'd0;

    apply(5'b10110, 5'b01101, 1'b1, "reset_cycle0");
    apply(5'b11111, 5'b11111, 1'b1, "reset_cycle1");

    apply(5'b00011, 5'b00101, 1'b0, "3+5");
    apply(5'b01111, 5'b00001, 1'b0, "15+1");
    apply(5'b10101, 5'b01011, 1'b0, "21+11_wrap32");
    apply(5'b11111, 5'b11111, 1'b0, "31+31");
    apply(5'b10010, 5'b01101, 1'b0, "18+13_allprop");
    apply(5'b00000, 5'b00000, 1'b0, "0+0");
    apply(5'b00111, 5'b00111, 1'b0, "7+7_hold0");
    apply(5'b00111, 5'b00111, 1'b0, "7+7_hold1");
    apply(5'b00111, 5'b00111, 1'b0, "7+7_hold2");

    apply(5'b11111, 5'b11111, 1'b1, "mid_reset_assert");
    apply(5'b11111, 5'b11111, 1'b1, "mid_reset_held");
    apply(5'b11111, 5'b11111, 1'b0, "mid_reset_release");

    for (int unsigned i = 0; i < 32; i++) begin
      for (int unsigned j = 0; j < 32; j++) begin
        apply(i, j, 1'b0, "sweep", (j % 8) == 3);
      end
    end

    for (int n = 0; n < 300; n++) begin
      ra = $urandom_range(31, 0);
      rb = $urandom_range(31, 0);
      rr = ($urandom_range(15, 0) == 0);
      apply(ra, rb, rr, rr ? "random_reset" : "random", $urandom_range(1, 0) == 1);
    end

    budget = 10;
    while (q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    done = 1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
